// File: rtl/seq_sub_pkg.sv
// Shared definitions for the sequential subtractor.
// The package holds the FSM state type and the default operand width.
package seq_sub_pkg;

    localparam int SUB_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sub16_slice.sv
// Combinational subtract slice: d = x + ~y + cin.
// cout is the inverse of the borrow out of this slice.
// Ports:
//   x, y  : slice operands (minuend, subtrahend)
//   cin   : carry in (inverse of the borrow in)
//   d     : slice difference
//   cout  : carry out (inverse of the borrow out)
module sub16_slice #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] d,
    output logic             cout
);

    logic [WIDTH:0] sum;

    assign sum  = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, cin};
    assign d    = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];

endmodule

// File: rtl/seq_sub32.sv
// Multi-cycle subtractor: diff = a - b - bin, computed as two half-width
// slices through one shared slice instance (low half, then high half using
// the registered low-half carry). Valid/ready handshake on both sides.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake
//   a, b, bin           : minuend, subtrahend, borrow-in
//   out_valid, out_ready: result handshake
//   diff, borrow, ovf   : result, unsigned borrow-out, signed overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// LO    | low half computed and registered this cycle
// HI    | high half, borrow and ovf registered this cycle
// DONE  | result valid and held until out_ready
module seq_sub32
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;

    state_t           state;
    state_t           state_next;
    logic             accept;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             bin_q;
    logic             carry_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic [HALF-1:0]  slice_x;
    logic [HALF-1:0]  slice_y;
    logic [HALF-1:0]  slice_d;
    logic             slice_cin;
    logic             slice_cout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = LO;
                end
            end
            LO:   state_next = HI;
            HI:   state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? LO : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Shared slice: low half in LO (borrow-in inverted into a carry),
    // high half in HI (chained on the registered low carry).
    always_comb begin
        slice_x   = a_q[HALF-1:0];
        slice_y   = b_q[HALF-1:0];
        slice_cin = ~bin_q;
        if (state == HI) begin
            slice_x   = a_q[WIDTH-1:HALF];
            slice_y   = b_q[WIDTH-1:HALF];
            slice_cin = carry_q;
        end
    end

    sub16_slice #(
        .WIDTH(HALF)
    ) u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .cin  (slice_cin),
        .d    (slice_d),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            bin_q    <= 1'b0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                bin_q <= bin;
            end
            if (state == LO) begin
                diff_q[HALF-1:0] <= slice_d;
                carry_q          <= slice_cout;
            end
            if (state == HI) begin
                diff_q[WIDTH-1:HALF] <= slice_d;
                borrow_q             <= ~slice_cout;
                // Overflow only when operand signs differ and the result
                // sign disagrees with the minuend.
                ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (slice_d[HALF-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_sub32.sv
module tb_seq_sub32;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_sub32 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issue one operation (releasing any held result in the same cycle),
    // then wait for its result and compare against plain integer arithmetic.
    task automatic do_op(input logic [31:0] a_v, input logic [31:0] b_v, input logic bin_v);
        logic [32:0] full;
        longint      sd;
        logic        exp_ovf;
        int          cyc;
        full    = {1'b0, a_v} - {1'b0, b_v} - {32'd0, bin_v};
        sd      = longint'($signed(a_v)) - longint'($signed(b_v)) - longint'(bin_v);
        exp_ovf = (sd > SMAX) || (sd < SMIN);
        a = a_v; b = b_v; bin = bin_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a   = $urandom;
        b   = $urandom;
        bin = 1'($urandom_range(0, 1));
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            @(negedge clk);
            cyc++;
        end
        chk("latency", 64'(cyc), 64'd3);
        chk("diff", 64'(diff), 64'(full[31:0]));
        chk("borrow", 64'(borrow), 64'(full[32]));
        chk("ovf", 64'(ovf), 64'(exp_ovf));
        chk("in_ready_stall", 64'(in_ready), 64'd0);
    endtask

    task automatic drain();
        logic [31:0] held;
        held      = diff;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_diff_hold", 64'(diff), 64'(held));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        do_op(32'd5, 32'd3, 1'b0);
        drain();
        do_op(32'h0001_0000, 32'h0000_0001, 1'b0);
        do_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        held = diff;
        repeat (4) begin
            @(negedge clk);
            chk("bp_diff_stable", 64'(diff), 64'(held));
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        do_op(32'd10, 32'd4, 1'b0);
        drain();

        // Reset while the high half is being computed.
        a = 32'd100; b = 32'd1; bin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_borrow", 64'(borrow), 64'd0);
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_result", 64'(out_valid), 64'd0);
        end

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ 32'h8000_0000;
                2: rb = {ra[31:16], rb[15:0]};
                default: ;
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) drain();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
